// File: rtl/atm_account_server_pkg.sv
// Shared sizing, enums and table entry layouts for the ATM account server.
package atm_account_server_pkg;

  localparam int PINCARD_SIZE    = 6;
  localparam int PASSWORD_SIZE   = 16;
  localparam int CREDIT_VAL_SIZE = 25;
  localparam int UP_LIMIT_SIZE   = 16;
  localparam int WITHDRAW_SIZE   = 16;
  localparam int ATM_CAP_SIZE    = 18;

  localparam int DEPTH          = 2 ** PINCARD_SIZE;
  localparam int ROM_DATA_WIDTH = 1 + PASSWORD_SIZE;
  localparam int RAM_DATA_WIDTH = UP_LIMIT_SIZE + CREDIT_VAL_SIZE;

  localparam logic [ATM_CAP_SIZE-1:0] ATM_CASH_INIT = 18'd100000;
  localparam int                      MAX_FAILS     = 3;

  typedef enum logic [2:0] {CHECK_PIN, BALANCE, DEPOSIT, WITHDRAW, TRANSFER} atm_op_e;

  typedef enum logic [2:0] {
    OK, BAD_CARD, BAD_PASS, INSUFF, OVER_LIMIT, ATM_EMPTY, OVERFLOW, BAD_DST
  } atm_status_e;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_RESP} srv_state_e;

  typedef struct packed {
    logic                     valid;
    logic [PASSWORD_SIZE-1:0] password;
  } rom_t;

  typedef struct packed {
    logic [UP_LIMIT_SIZE-1:0]   up_limit;
    logic [CREDIT_VAL_SIZE-1:0] credit;
  } ram_t;

endpackage

// File: rtl/atm_account_mem.sv
// Card/password and account tables: two combinational read ports, cfg write,
// two account write ports (source/destination, never the same index) and a valid-clear port.
module atm_account_mem
  import atm_account_server_pkg::*;
(
  input  logic                      clk,
  input  logic [PINCARD_SIZE-1:0]   rd_a_addr_i,
  output logic [ROM_DATA_WIDTH-1:0] rd_a_rom_o,
  output logic [RAM_DATA_WIDTH-1:0] rd_a_ram_o,
  input  logic [PINCARD_SIZE-1:0]   rd_b_addr_i,
  output logic                      rd_b_valid_o,
  output logic [RAM_DATA_WIDTH-1:0] rd_b_ram_o,
  input  logic                      cfg_we_i,
  input  logic [PINCARD_SIZE-1:0]   cfg_addr_i,
  input  logic [ROM_DATA_WIDTH-1:0] cfg_rom_i,
  input  logic [RAM_DATA_WIDTH-1:0] cfg_ram_i,
  input  logic                      wa_we_i,
  input  logic [PINCARD_SIZE-1:0]   wa_addr_i,
  input  logic [RAM_DATA_WIDTH-1:0] wa_ram_i,
  input  logic                      wb_we_i,
  input  logic [PINCARD_SIZE-1:0]   wb_addr_i,
  input  logic [RAM_DATA_WIDTH-1:0] wb_ram_i,
  input  logic                      inv_we_i,
  input  logic [PINCARD_SIZE-1:0]   inv_addr_i
);

  logic [ROM_DATA_WIDTH-1:0] rom_q [DEPTH];
  logic [RAM_DATA_WIDTH-1:0] ram_q [DEPTH];

  assign rd_a_rom_o   = rom_q[rd_a_addr_i];
  assign rd_a_ram_o   = ram_q[rd_a_addr_i];
  assign rd_b_valid_o = rom_q[rd_b_addr_i][ROM_DATA_WIDTH-1];
  assign rd_b_ram_o   = ram_q[rd_b_addr_i];

  // Table contents survive reset; cfg writes and commits never share a cycle.
  always_ff @(posedge clk) begin
    if (cfg_we_i) begin
      rom_q[cfg_addr_i] <= cfg_rom_i;
      ram_q[cfg_addr_i] <= cfg_ram_i;
    end
    if (wa_we_i) ram_q[wa_addr_i] <= wa_ram_i;
    if (wb_we_i) ram_q[wb_addr_i] <= wb_ram_i;
    if (inv_we_i) rom_q[inv_addr_i][ROM_DATA_WIDTH-1] <= 1'b0;
  end

endmodule

// File: rtl/atm_account_server.sv
// ATM account server: IDLE->READ->EXEC->RESP, updates commit on the EXEC->RESP edge.
// Define ATM_SERVER_LOCKOUT_EN to invalidate a card after MAX_FAILS consecutive bad passwords.
module atm_account_server
  import atm_account_server_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [PINCARD_SIZE-1:0]    cfg_card,
  input  logic                       cfg_valid,
  input  logic [PASSWORD_SIZE-1:0]   cfg_pass,
  input  logic [UP_LIMIT_SIZE-1:0]   cfg_limit,
  input  logic [CREDIT_VAL_SIZE-1:0] cfg_credit,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_op,
  input  logic [PINCARD_SIZE-1:0]    req_card,
  input  logic [PASSWORD_SIZE-1:0]   req_pass,
  input  logic [PINCARD_SIZE-1:0]    req_dst,
  input  logic [WITHDRAW_SIZE-1:0]   req_amount,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2:0]                 rsp_status,
  output logic [CREDIT_VAL_SIZE-1:0] rsp_balance,
  output logic [ATM_CAP_SIZE-1:0]    atm_cash
);

  srv_state_e                 state_q, state_d;
  logic [2:0]                 op_q;
  logic [PINCARD_SIZE-1:0]    card_q, dst_q;
  logic [PASSWORD_SIZE-1:0]   pass_q;
  logic [WITHDRAW_SIZE-1:0]   amt_q;
  rom_t                       src_rom_q;
  ram_t                       src_ram_q, dst_ram_q;
  logic                       dst_valid_q;
  logic [2:0]                 status_q;
  logic [CREDIT_VAL_SIZE-1:0] bal_q;
  logic [ATM_CAP_SIZE-1:0]    cash_q;

  logic [ROM_DATA_WIDTH-1:0]  rd_a_rom;
  logic [RAM_DATA_WIDTH-1:0]  rd_a_ram, rd_b_ram;
  logic                       rd_b_valid;
  logic                       accept, cfg_fire, commit, inv_we, wr_src, wr_dst;
  atm_status_e                status_d;
  logic [CREDIT_VAL_SIZE-1:0] bal_d, src_cred_d, dst_cred_d;
  logic [ATM_CAP_SIZE-1:0]    cash_d;
  logic [CREDIT_VAL_SIZE:0]   dep_sum, xfer_sum;
  logic [ATM_CAP_SIZE:0]      cash_sum;
  logic [CREDIT_VAL_SIZE-1:0] amt_c;
  logic [ATM_CAP_SIZE-1:0]    amt_cash;
  logic                       over_limit, insuff;

  assign req_ready   = (state_q == S_IDLE) && !cfg_we;
  assign accept      = req_valid && req_ready;
  assign cfg_fire    = cfg_we && (state_q == S_IDLE);
  assign commit      = (state_q == S_EXEC);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_status  = status_q;
  assign rsp_balance = bal_q;
  assign atm_cash    = cash_q;

  atm_account_mem u_mem (
    .clk          (clk),
    .rd_a_addr_i  (card_q),
    .rd_a_rom_o   (rd_a_rom),
    .rd_a_ram_o   (rd_a_ram),
    .rd_b_addr_i  (dst_q),
    .rd_b_valid_o (rd_b_valid),
    .rd_b_ram_o   (rd_b_ram),
    .cfg_we_i     (cfg_fire),
    .cfg_addr_i   (cfg_card),
    .cfg_rom_i    ({cfg_valid, cfg_pass}),
    .cfg_ram_i    ({cfg_limit, cfg_credit}),
    .wa_we_i      (commit && wr_src),
    .wa_addr_i    (card_q),
    .wa_ram_i     ({src_ram_q.up_limit, src_cred_d}),
    .wb_we_i      (commit && wr_dst),
    .wb_addr_i    (dst_q),
    .wb_ram_i     ({dst_ram_q.up_limit, dst_cred_d}),
    .inv_we_i     (inv_we),
    .inv_addr_i   (card_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign amt_c      = CREDIT_VAL_SIZE'(amt_q);
  assign amt_cash   = ATM_CAP_SIZE'(amt_q);
  assign dep_sum    = {1'b0, src_ram_q.credit} + {1'b0, amt_c};
  assign xfer_sum   = {1'b0, dst_ram_q.credit} + {1'b0, amt_c};
  assign cash_sum   = {1'b0, cash_q} + {1'b0, amt_cash};
  assign over_limit = amt_q > src_ram_q.up_limit;
  assign insuff     = amt_c > src_ram_q.credit;

  // Check priority: card, password, then the op-specific rules; first failure wins.
  always_comb begin
    status_d   = OK;
    bal_d      = src_ram_q.credit;
    src_cred_d = src_ram_q.credit;
    dst_cred_d = dst_ram_q.credit;
    cash_d     = cash_q;
    wr_src     = 1'b0;
    wr_dst     = 1'b0;
    if (!src_rom_q.valid) begin
      status_d = BAD_CARD;
      bal_d    = '0;
    end else if (src_rom_q.password != pass_q) begin
      status_d = BAD_PASS;
      bal_d    = '0;
    end else begin
      case (op_q)
        CHECK_PIN, BALANCE: status_d = OK;
        DEPOSIT: begin
          if (dep_sum[CREDIT_VAL_SIZE]) status_d = OVERFLOW;
          else begin
            src_cred_d = dep_sum[CREDIT_VAL_SIZE-1:0];
            cash_d     = cash_sum[ATM_CAP_SIZE] ? '1 : cash_sum[ATM_CAP_SIZE-1:0];
            wr_src     = 1'b1;
          end
        end
        WITHDRAW: begin
          if (over_limit)             status_d = OVER_LIMIT;
          else if (insuff)            status_d = INSUFF;
          else if (amt_cash > cash_q) status_d = ATM_EMPTY;
          else begin
            src_cred_d = src_ram_q.credit - amt_c;
            cash_d     = cash_q - amt_cash;
            wr_src     = 1'b1;
          end
        end
        TRANSFER: begin
          if (!dst_valid_q || (dst_q == card_q)) status_d = BAD_DST;
          else if (over_limit)                   status_d = OVER_LIMIT;
          else if (insuff)                       status_d = INSUFF;
          else if (xfer_sum[CREDIT_VAL_SIZE])    status_d = OVERFLOW;
          else begin
            src_cred_d = src_ram_q.credit - amt_c;
            dst_cred_d = xfer_sum[CREDIT_VAL_SIZE-1:0];
            wr_src     = 1'b1;
            wr_dst     = 1'b1;
          end
        end
        default: status_d = BAD_DST;
      endcase
      if (status_d == OK) bal_d = src_cred_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      card_q      <= '0;
      dst_q       <= '0;
      pass_q      <= '0;
      amt_q       <= '0;
      src_rom_q   <= '0;
      src_ram_q   <= '0;
      dst_ram_q   <= '0;
      dst_valid_q <= 1'b0;
      status_q    <= OK;
      bal_q       <= '0;
      cash_q      <= ATM_CASH_INIT;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= req_op;
        card_q <= req_card;
        dst_q  <= req_dst;
        pass_q <= req_pass;
        amt_q  <= req_amount;
      end
      if (state_q == S_READ) begin
        src_rom_q   <= rom_t'(rd_a_rom);
        src_ram_q   <= ram_t'(rd_a_ram);
        dst_ram_q   <= ram_t'(rd_b_ram);
        dst_valid_q <= rd_b_valid;
      end
      if (commit) begin
        status_q <= status_d;
        bal_q    <= bal_d;
        cash_q   <= cash_d;
      end
    end
  end

`ifdef ATM_SERVER_LOCKOUT_EN
  logic [1:0] fail_q [DEPTH];
  logic [1:0] fail_inc;

  assign fail_inc = fail_q[card_q] + 2'd1;
  assign inv_we   = commit && (status_d == BAD_PASS) && (fail_inc == 2'(MAX_FAILS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fail_q[i] <= '0;
    end else if (cfg_fire) begin
      fail_q[cfg_card] <= '0;
    end else if (commit && (status_d == BAD_PASS)) begin
      fail_q[card_q] <= fail_inc;
    end else if (commit && (status_d == OK)) begin
      fail_q[card_q] <= '0;
    end
  end
`else
  assign inv_we = 1'b0;
`endif

endmodule
